// File: rtl/sr_chk_pkg.sv
// Shared definitions for the SR latch checker.
// Holds the FSM state encoding and the default mismatch counter width.
package sr_chk_pkg;

    localparam int CNT_W_DEF = 8;

    // 2'd3 is unused and decodes as UNINIT.
    typedef enum logic [1:0] {
        UNINIT  = 2'd0,
        TRACK   = 2'd1,
        ILLEGAL = 2'd2
    } chk_state_e;

endpackage

// File: rtl/sr_model.sv
// Reference model of the observed SR latch: next expected q and legality.
// Ports: mon_s/mon_r/mon_en/mon_rst/exp_q in; exp_next, illegal, drive out.
module sr_model (
    input  logic mon_s,
    input  logic mon_r,
    input  logic mon_en,
    input  logic mon_rst,
    input  logic exp_q,
    output logic exp_next,
    output logic illegal,
    output logic drive
);

    always_comb begin
        exp_next = exp_q;
        illegal  = 1'b0;
        unique case (1'b1)
            mon_rst: exp_next = 1'b0;
            !mon_rst && !mon_en: exp_next = exp_q;
            !mon_rst && mon_en: begin
                unique case ({mon_s, mon_r})
                    2'b10:   exp_next = 1'b1;
                    2'b01:   exp_next = 1'b0;
                    2'b11:   illegal  = 1'b1;
                    default: exp_next = exp_q;
                endcase
            end
        endcase
    end

    // A legal set or reset gives the model a known value again.
    assign drive = !mon_rst && mon_en && (mon_s ^ mon_r);

endmodule

// File: rtl/sr_latch_checker.sv
// Passive monitor comparing an observed SR latch against a one-cycle model.
// Ports: clk, rst (sync, low), chk_en, mon_* in; err, err_cnt, illegal_seen, state out.
module sr_latch_checker
    import sr_chk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_en,
    input  logic             mon_s,
    input  logic             mon_r,
    input  logic             mon_en,
    input  logic             mon_rst,
    input  logic             mon_q,
    input  logic             mon_qb,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             illegal_seen,
    output logic [1:0]       state
);

    chk_state_e cur_st;
    chk_state_e nxt_st;
    logic       exp_q;
    logic       exp_next;
    logic       illegal;
    logic       drive;
    logic       mismatch;

    sr_model u_model (
        .mon_s    (mon_s),
        .mon_r    (mon_r),
        .mon_en   (mon_en),
        .mon_rst  (mon_rst),
        .exp_q    (exp_q),
        .exp_next (exp_next),
        .illegal  (illegal),
        .drive    (drive)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_st <= UNINIT;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st = cur_st;
        if (chk_en) begin
            case (cur_st)
                TRACK: begin
                    if (illegal) nxt_st = ILLEGAL;
                end
                ILLEGAL: begin
                    if (mon_rst || drive) nxt_st = TRACK;
                end
                default: begin
                    if (mon_rst || drive) nxt_st = TRACK;
                    else if (illegal)     nxt_st = ILLEGAL;
                end
            endcase
        end
    end

    // exp_q was set from last cycle's inputs, so this cycle's q must match it.
    assign mismatch = (cur_st == TRACK) &&
                      ((mon_q != exp_q) || (mon_qb == mon_q));

    always_ff @(posedge clk) begin
        if (!rst) begin
            exp_q        <= 1'b0;
            err          <= 1'b0;
            err_cnt      <= '0;
            illegal_seen <= 1'b0;
        end else if (chk_en) begin
            exp_q <= exp_next;
            err   <= mismatch;
            if (mismatch && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
            if (illegal) begin
                illegal_seen <= 1'b1;
            end
        end else begin
            err <= 1'b0;
        end
    end

    assign state = cur_st;

endmodule

// File: tb/tb_sr_latch_checker.sv
// Scoreboard bench for sr_latch_checker (default width and CNT_W=2 instances).
// Expected outputs come from a bench-side latch model queued per driven cycle.
module tb_sr_latch_checker;

    typedef struct packed {
        logic rst;
        logic ce;
        logic en;
        logic mrst;
        logic s;
        logic r;
        logic q;
        logic qb;
    } stim_t;

    typedef logic [17:0] obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       chk_en;
    logic       mon_s;
    logic       mon_r;
    logic       mon_en;
    logic       mon_rst;
    logic       mon_q;
    logic       mon_qb;
    logic       err;
    logic [7:0] err_cnt;
    logic       illegal_seen;
    logic [1:0] state;
    logic       err_s;
    logic [1:0] err_cnt_s;
    logic       illegal_seen_s;
    logic [1:0] state_s;

    logic [1:0] m_state;
    logic       m_exp;
    logic       m_err;
    logic [7:0] m_cnt;
    logic [1:0] m_cnt2;
    logic       m_ill;

    obs_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sr_latch_checker u_dut (
        .clk          (clk),
        .rst          (rst),
        .chk_en       (chk_en),
        .mon_s        (mon_s),
        .mon_r        (mon_r),
        .mon_en       (mon_en),
        .mon_rst      (mon_rst),
        .mon_q        (mon_q),
        .mon_qb       (mon_qb),
        .err          (err),
        .err_cnt      (err_cnt),
        .illegal_seen (illegal_seen),
        .state        (state)
    );

    sr_latch_checker #(.CNT_W(2)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .chk_en       (chk_en),
        .mon_s        (mon_s),
        .mon_r        (mon_r),
        .mon_en       (mon_en),
        .mon_rst      (mon_rst),
        .mon_q        (mon_q),
        .mon_qb       (mon_qb),
        .err          (err_s),
        .err_cnt      (err_cnt_s),
        .illegal_seen (illegal_seen_s),
        .state        (state_s)
    );

    function automatic stim_t mk(input logic a, b, c, d, e, f, g, h);
        return {a, b, c, d, e, f, g, h};
    endfunction

    function automatic obs_t obs();
        return {err, err_cnt, illegal_seen, state,
                err_s, err_cnt_s, illegal_seen_s, state_s};
    endfunction

    // Drive one cycle, step the bench model, queue its expectation.
    task automatic cycle(input stim_t st);
        logic mm;
        logic ill;
        logic drv;
        rst     = st.rst;
        chk_en  = st.ce;
        mon_en  = st.en;
        mon_rst = st.mrst;
        mon_s   = st.s;
        mon_r   = st.r;
        mon_q   = st.q;
        mon_qb  = st.qb;
        if (!st.rst) begin
            m_state = 2'd0;
            m_exp   = 1'b0;
            m_err   = 1'b0;
            m_cnt   = 8'd0;
            m_cnt2  = 2'd0;
            m_ill   = 1'b0;
        end else if (st.ce) begin
            mm  = (m_state == 2'd1) && ((st.q != m_exp) || (st.qb != !st.q));
            ill = st.en && !st.mrst && st.s && st.r;
            drv = st.en && !st.mrst && (st.s != st.r);
            m_err = mm;
            if (mm && m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
            if (mm && m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
            if (st.mrst) m_exp = 1'b0;
            else if (drv) m_exp = st.s;
            if (m_state == 2'd1) begin
                if (ill) m_state = 2'd2;
            end else begin
                if (st.mrst || drv) m_state = 2'd1;
                else if (ill) m_state = 2'd2;
            end
            if (ill) m_ill = 1'b1;
        end else begin
            m_err = 1'b0;
        end
        sb_q.push_back({m_err, m_cnt, m_ill, m_state,
                        m_err, m_cnt2, m_ill, m_state});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t exp_v;
        obs_t got;
        for (int i = 0; i < 2; i++) begin
            cycle(mk(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)));
            exp_v = sb_q.pop_front();
            got = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset_sb cyc %0d: got %h expected %h", i, got, exp_v);
            end
        end
        checks++;
        if ({state, err_cnt, illegal_seen, err} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outs: got st=%0d cnt=%0d ill=%b err=%b expected 0",
                     state, err_cnt, illegal_seen, err);
        end
    endtask

    task automatic test_correct();
        stim_t seq[$];
        obs_t  exp_v;
        obs_t  got;
        int    pulses = 0;
        seq.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1));
        seq.push_back(mk(1, 1, 1, 0, 1, 0, 0, 1));
        seq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0));
        seq.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0));
        seq.push_back(mk(1, 1, 1, 0, 0, 1, 1, 0));
        seq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1));
        seq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1));
        foreach (seq[i]) begin
            cycle(seq[i]);
            exp_v = sb_q.pop_front();
            got = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL correct_sb cyc %0d: got %h expected %h", i, got, exp_v);
            end
            if (err === 1'b1) pulses++;
        end
        checks++;
        if (state !== 2'd1 || err_cnt !== 8'd0 || pulses != 0) begin
            errors++;
            $display("FAIL correct_end: got st=%0d cnt=%0d pulses=%0d expected 1/0/0",
                     state, err_cnt, pulses);
        end
    endtask

    task automatic test_fault();
        stim_t seq[$];
        obs_t  exp_v;
        obs_t  got;
        int    pulses = 0;
        seq.push_back(mk(1, 1, 1, 0, 1, 0, 0, 1));
        seq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1));
        seq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1));
        seq.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1));
        seq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0));
        foreach (seq[i]) begin
            cycle(seq[i]);
            exp_v = sb_q.pop_front();
            got = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL fault_sb cyc %0d: got %h expected %h", i, got, exp_v);
            end
            if (err === 1'b1) pulses++;
        end
        checks++;
        if (err_cnt !== 8'd3 || pulses != 3) begin
            errors++;
            $display("FAIL fault_cnt: got cnt=%0d pulses=%0d expected 3/3", err_cnt, pulses);
        end
    endtask

    task automatic test_illegal();
        stim_t seq[$];
        obs_t  exp_v;
        obs_t  got;
        int    pulses = 0;
        seq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
        seq.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1));
        seq.push_back(mk(1, 1, 1, 0, 1, 1, 0, 1));
        seq.push_back(mk(1, 1, 1, 0, 1, 1, 1, 1));
        seq.push_back(mk(1, 1, 1, 0, 1, 1, 1, 1));
        seq.push_back(mk(1, 1, 1, 0, 0, 1, 1, 1));
        seq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0));
        seq.push_back(mk(1, 1, 1, 0, 1, 1, 1, 0));
        foreach (seq[i]) begin
            cycle(seq[i]);
            exp_v = sb_q.pop_front();
            got = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL illegal_sb cyc %0d: got %h expected %h", i, got, exp_v);
            end
            if (err === 1'b1) pulses++;
            if (i == 2) begin
                checks++;
                if (illegal_seen !== 1'b1 || state !== 2'd2) begin
                    errors++;
                    $display("FAIL illegal_enter: got ill=%b st=%0d expected 1/2",
                             illegal_seen, state);
                end
            end
            if (i == 6) begin
                checks++;
                if (err !== 1'b1 || state !== 2'd1) begin
                    errors++;
                    $display("FAIL illegal_resume: got err=%b st=%0d expected 1/1", err, state);
                end
            end
        end
        checks++;
        if (err !== 1'b1 || state !== 2'd2 || pulses != 2) begin
            errors++;
            $display("FAIL illegal_same_cyc: got err=%b st=%0d pulses=%0d expected 1/2/2",
                     err, state, pulses);
        end
    endtask

    task automatic test_saturation();
        stim_t seq[$];
        obs_t  exp_v;
        obs_t  got;
        int    pulses = 0;
        seq.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
        seq.push_back(mk(1, 1, 0, 1, 0, 0, 0, 1));
        for (int k = 0; k < 6; k++) seq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0));
        foreach (seq[i]) begin
            cycle(seq[i]);
            exp_v = sb_q.pop_front();
            got = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL sat_sb cyc %0d: got %h expected %h", i, got, exp_v);
            end
            if (err_s === 1'b1) pulses++;
        end
        checks++;
        if (err_cnt_s !== 2'd3 || err_cnt !== 8'd6 || pulses != 6) begin
            errors++;
            $display("FAIL sat_cnt: got cnt2=%0d cnt8=%0d pulses=%0d expected 3/6/6",
                     err_cnt_s, err_cnt, pulses);
        end
    endtask

    task automatic test_freeze_reset();
        stim_t seq[$];
        obs_t  exp_v;
        obs_t  got;
        seq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0));
        seq.push_back(mk(1, 0, 1, 0, 1, 1, 1, 0));
        seq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0));
        seq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0));
        seq.push_back(mk(1, 1, 1, 0, 1, 1, 1, 0));
        seq.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0));
        seq.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0));
        foreach (seq[i]) begin
            cycle(seq[i]);
            exp_v = sb_q.pop_front();
            got = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL freeze_sb cyc %0d: got %h expected %h", i, got, exp_v);
            end
            if (i == 2) begin
                checks++;
                if (err !== 1'b0 || err_cnt !== 8'd6 || illegal_seen !== 1'b0 ||
                    state !== 2'd1) begin
                    errors++;
                    $display("FAIL freeze_hold: got err=%b cnt=%0d ill=%b st=%0d expected 0/6/0/1",
                             err, err_cnt, illegal_seen, state);
                end
            end
            if (i == 5) begin
                checks++;
                if ({err, err_cnt, err_cnt_s, illegal_seen, state} !== 14'd0) begin
                    errors++;
                    $display("FAIL midrun_reset: got err=%b cnt=%0d cnt2=%0d ill=%b st=%0d expected 0",
                             err, err_cnt, err_cnt_s, illegal_seen, state);
                end
            end
        end
        checks++;
        if (err !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL post_reset_uninit: got err=%b st=%0d expected 0/0", err, state);
        end
    endtask

    task automatic test_random();
        obs_t exp_v;
        obs_t got;
        logic q;
        for (int i = 0; i < 400; i++) begin
            q = 1'($urandom);
            cycle(mk(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) != 0),
                     1'($urandom), ($urandom_range(0, 7) == 0),
                     1'($urandom), 1'($urandom), q,
                     ($urandom_range(0, 7) == 0) ? q : !q));
            exp_v = sb_q.pop_front();
            got = obs();
            checks++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL random_sb cyc %0d: got %h expected %h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        chk_en = 1'b0;
        mon_s = 1'b0;
        mon_r = 1'b0;
        mon_en = 1'b0;
        mon_rst = 1'b0;
        mon_q = 1'b0;
        mon_qb = 1'b1;
        #1;
        test_reset();
        test_correct();
        test_fault();
        test_illegal();
        test_saturation();
        test_freeze_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
